// File: rtl/fp_to_int.sv
// Multi-cycle IEEE-754 single-precision to 32-bit signed integer converter.
// Fixed 5-clock latency; truncate or round-to-nearest-even on the magnitude.
module fp_to_int #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        round_mode,
  input  logic [31:0] input_a,
  output logic [31:0] output_z,
  output logic        overflow,
  output logic        underflow,
  output logic        busy,
  output logic        output_done
);

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SPECIAL_CASES,
    SHIFT,
    ROUND,
    PACK
  } state_t;

  state_t state, state_next;

  logic [31:0] a_q;
  logic        rne_q;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [23:0] man_q;
  logic        is_zero_q, is_denorm_q, is_nan_q, is_ovf_q, is_min_q;
  logic [31:0] mag_q;
  logic        guard_q, sticky_q;

  logic [7:0]  rshift;
  logic [2:0]  lshift;
  logic [47:0] ext;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (start) state_next = UNPACK;
      UNPACK:        state_next = SPECIAL_CASES;
      SPECIAL_CASES: state_next = SHIFT;
      SHIFT:         state_next = ROUND;
      ROUND:         state_next = PACK;
      PACK:          state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Left shift is exp-150 for exp in 150..157; 150 mod 8 = 6, so the low bits suffice.
  always_comb begin
    rshift = 8'd150 - exp_q;
    lshift = exp_q[2:0] - 3'd6;
    ext    = {man_q, 24'd0} >> rshift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output_z    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      output_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q         <= input_a;
            rne_q       <= round_mode;
            output_done <= 1'b0;
          end
        end
        UNPACK: begin
          sign_q <= a_q[31];
          exp_q  <= a_q[30:23];
          man_q  <= {1'b1, a_q[22:0]};
        end
        SPECIAL_CASES: begin
          is_nan_q    <= (exp_q == 8'hFF) && (man_q[22:0] != '0);
          is_zero_q   <= (exp_q == 8'h00) && (man_q[22:0] == '0);
          is_denorm_q <= (exp_q == 8'h00) && (man_q[22:0] != '0);
          // -2^31 is the single e=31 value that still fits.
          is_min_q    <= sign_q && (exp_q == 8'd158) && (man_q[22:0] == '0);
          is_ovf_q    <= (exp_q == 8'hFF) ||
                         ((exp_q >= 8'd158) &&
                          !(sign_q && (exp_q == 8'd158) && (man_q[22:0] == '0)));
        end
        SHIFT: begin
          if (exp_q >= 8'd150) begin
            mag_q    <= {8'd0, man_q} << lshift;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
          end else if (exp_q >= 8'd126) begin
            mag_q    <= {8'd0, ext[47:24]};
            guard_q  <= ext[23];
            sticky_q <= |ext[22:0];
          end else begin
            mag_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b1;
          end
        end
        ROUND: begin
          if (rne_q && guard_q && (sticky_q || mag_q[0]))
            mag_q <= mag_q + 32'd1;
        end
        PACK: begin
          output_done <= 1'b1;
          if (is_ovf_q) begin
            overflow  <= 1'b1;
            underflow <= 1'b0;
            output_z  <= (SATURATE && (is_nan_q || !sign_q)) ? 32'h7FFFFFFF : 32'h80000000;
          end else if (is_min_q) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            output_z  <= 32'h80000000;
          end else if (is_zero_q) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            output_z  <= '0;
          end else if (is_denorm_q) begin
            overflow  <= 1'b0;
            underflow <= 1'b1;
            output_z  <= '0;
          end else begin
            overflow  <= 1'b0;
            underflow <= (mag_q == '0);
            output_z  <= sign_q ? -mag_q : mag_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: directed corner values, randomized operands
// against an arithmetic reference model, handshake and reset-abort scenarios.
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        round_mode = 1'b0;
  logic [31:0] input_a = '0;

  logic [31:0] z1, z0;
  logic        ovf1, unf1, busy1, done1;
  logic        ovf0, unf0, busy0, done0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_to_int #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .round_mode(round_mode), .input_a(input_a),
    .output_z(z1), .overflow(ovf1), .underflow(unf1), .busy(busy1), .output_done(done1)
  );

  fp_to_int #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .round_mode(round_mode), .input_a(input_a),
    .output_z(z0), .overflow(ovf0), .underflow(unf0), .busy(busy0), .output_done(done0)
  );

  // Value-level reference: exact integer division of the significand by a power of two.
  function automatic void model(input logic [31:0] a, input bit rne, input bit sat,
                                output logic [31:0] z, output bit ovf, output bit unf);
    int     ex;
    int     e;
    bit     s;
    longint m, mag, den, q, r, val;
    ex  = int'(a[30:23]);
    s   = a[31];
    ovf = 1'b0;
    unf = 1'b0;
    z   = '0;
    if (ex == 255) begin
      ovf = 1'b1;
      z   = (sat && (a[22:0] != 0 || !s)) ? 32'h7FFFFFFF : 32'h80000000;
      return;
    end
    if (ex == 0) begin
      unf = (a[22:0] != 0);
      return;
    end
    e = ex - 127;
    m = longint'({1'b1, a[22:0]});
    if (e >= 40) mag = longint'(1) << 40;
    else if (e >= 23) mag = m << (e - 23);
    else if (e < -2) mag = 0;
    else begin
      den = longint'(1) << (23 - e);
      q   = m / den;
      r   = m % den;
      if (rne && ((2 * r > den) || ((2 * r == den) && (q % 2 == 1)))) q = q + 1;
      mag = q;
    end
    val = s ? -mag : mag;
    if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
      ovf = 1'b1;
      z   = (sat && !s) ? 32'h7FFFFFFF : 32'h80000000;
    end else begin
      z   = val[31:0];
      unf = (mag == 0);
    end
  endfunction

  task automatic do_conv(input string name, input logic [31:0] a, input bit mode,
                         input logic [31:0] ez, input bit eovf, input bit eunf,
                         input logic [31:0] ez0);
    int lat;
    start      = 1'b1;
    input_a    = a;
    round_mode = mode;
    @(posedge clk); #1;
    start      = 1'b0;
    input_a    = $urandom;
    round_mode = 1'($urandom);
    n_checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", name, busy1, done1);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (done1 !== 1'b1 && lat < 10);
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL %s latency: got %0d clocks, required 5", name, lat);
    end
    n_checks++;
    if ({z1, ovf1, unf1, busy1} !== {ez, eovf, eunf, 1'b0}) begin
      n_fail++;
      $display("FAIL %s result a=%h mode=%0d: got z=%h ovf=%b unf=%b busy=%b, required z=%h ovf=%b unf=%b busy=0",
               name, a, mode, z1, ovf1, unf1, busy1, ez, eovf, eunf);
    end
    n_checks++;
    if (z0 !== ez0 || done0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s nosat a=%h: got z=%h done=%b, required z=%h done=1", name, a, z0, done0, ez0);
    end
    n_checks++;
    if (ovf1 && unf1) begin
      n_fail++;
      $display("FAIL %s flags: got ovf=1 unf=1, required not both", name);
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    start      = 1'b1;
    input_a    = 32'h40600000;
    round_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({z1, ovf1, unf1, busy1, done1} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state: got z=%h ovf=%b unf=%b busy=%b done=%b, required all 0",
               z1, ovf1, unf1, busy1, done1);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: got busy=%b done=%b, required 0 0", busy1, done1);
    end
  endtask

  task automatic test_directed;
    logic [31:0] va  [16] = '{32'h40200000, 32'h40600000, 32'hC0200000, 32'h40600000,
                              32'h42F6E666, 32'h42F6E666, 32'h4F000000, 32'hCF000000,
                              32'h3F000000, 32'h3F000001, 32'h3F000001, 32'h00000001,
                              32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h4EFFFFFF};
    bit          vm  [16] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    logic [31:0] vz  [16] = '{32'd2, 32'd4, 32'hFFFFFFFE, 32'd3, 32'd123, 32'd123,
                              32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd1, 32'd0, 32'd0,
                              32'd0, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80};
    bit          vo  [16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    bit          vu  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
    logic [31:0] vz0 [16] = '{32'd2, 32'd4, 32'hFFFFFFFE, 32'd3, 32'd123, 32'd123,
                              32'h80000000, 32'h80000000, 32'd0, 32'd1, 32'd0, 32'd0,
                              32'd0, 32'h80000000, 32'h80000000, 32'h7FFFFF80};
    for (int i = 0; i < 16; i++)
      do_conv($sformatf("directed%0d", i), va[i], vm[i], vz[i], vo[i], vu[i], vz0[i]);
  endtask

  task automatic test_random;
    logic [31:0] a, ez, ez0;
    bit          mode, eovf, eunf, d0, d1;
    for (int i = 0; i < 150; i++) begin
      if (i % 4 == 0) a = $urandom;
      else a = {1'($urandom), 8'($urandom_range(120, 160)), 23'($urandom)};
      if (i % 16 == 1) a[22:0] = {1'b1, 22'd0};
      mode = 1'($urandom);
      model(a, mode, 1'b1, ez, eovf, eunf);
      model(a, mode, 1'b0, ez0, d0, d1);
      do_conv($sformatf("random%0d", i), a, mode, ez, eovf, eunf, ez0);
    end
  endtask

  task automatic test_hold;
    logic [31:0] ez, ez0;
    bit          eovf, eunf, d0, d1;
    model(32'hC2F6E666, 1'b1, 1'b1, ez, eovf, eunf);
    model(32'hC2F6E666, 1'b1, 1'b0, ez0, d0, d1);
    do_conv("hold_setup", 32'hC2F6E666, 1'b1, ez, eovf, eunf, ez0);
    for (int k = 0; k < 4; k++) begin
      input_a    = $urandom;
      round_mode = 1'($urandom);
      @(posedge clk); #1;
    end
    n_checks++;
    if ({z1, ovf1, unf1, done1, busy1} !== {ez, eovf, eunf, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hold: got z=%h done=%b busy=%b, required z=%h done=1 busy=0", z1, done1, busy1, ez);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ops [7];
    logic [31:0] ez, ez0;
    bit          eovf, eunf;
    int          lat;
    for (int i = 0; i < 7; i++)
      ops[i] = {1'($urandom), 8'($urandom_range(127, 150)), 23'($urandom)};
    start      = 1'b1;
    round_mode = 1'b1;
    input_a    = ops[0];
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      input_a = ops[k + 1];
      n_checks++;
      if (k < 5 && (busy1 !== 1'b1 || done1 !== 1'b0)) begin
        n_fail++;
        $display("FAIL b2b_busy E%0d: got busy=%b done=%b, required 1 0", k, busy1, done1);
      end else if (k == 5) begin
        model(ops[0], 1'b1, 1'b1, ez, eovf, eunf);
        if ({z1, done1, busy1} !== {ez, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL b2b_first E5: got z=%h done=%b busy=%b, required z=%h done=1 busy=0",
                   z1, done1, busy1, ez);
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept E6: got busy=%b done=%b, required 1 0", busy1, done1);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (done1 !== 1'b1 && lat < 10);
    model(ops[6], 1'b1, 1'b1, ez, eovf, eunf);
    n_checks++;
    if (lat != 5 || z1 !== ez) begin
      n_fail++;
      $display("FAIL b2b_second: got z=%h after %0d clocks, required z=%h after 5", z1, lat, ez);
    end
    model(ops[6], 1'b1, 1'b0, ez0, eovf, eunf);
    n_checks++;
    if (z0 !== ez0) begin
      n_fail++;
      $display("FAIL b2b_nosat: got z=%h, required %h", z0, ez0);
    end
  endtask

  task automatic test_reset_abort;
    bit seen_done;
    start      = 1'b1;
    input_a    = 32'h42F6E666;
    round_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({z1, ovf1, unf1, busy1, done1} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL abort_reset: got z=%h ovf=%b unf=%b busy=%b done=%b, required all 0",
               z1, ovf1, unf1, busy1, done1);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL abort_no_done: got done/busy activity after reset, required none");
    end
    do_conv("after_abort", 32'h40600000, 1'b0, 32'd3, 1'b0, 1'b0, 32'd3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL have parameter: SATURATE, 1, out-of-range/NaN result select (1: clamp by sign; 0: always 32'h80000000).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a conversion; accepted only when busy=0.
REQ-005 SHALL have port: round_mode  input  1  0 = truncate toward zero, 1 = round to nearest, ties to even.
REQ-006 SHALL have port: input_a  input  32  IEEE-754 single-precision operand.
REQ-007 SHALL have port: output_z  output  32  signed two's-complement integer result.
REQ-008 SHALL have port: overflow  output  1  result not representable in 32-bit signed.
REQ-009 SHALL have port: underflow  output  1  nonzero input produced integer 0.
REQ-010 SHALL have port: busy  output  1  conversion in progress.
REQ-011 SHALL have port: output_done  output  1  result valid; level, held until next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, UNPACK, SPECIAL_CASES, SHIFT, ROUND, PACK; one state per clock, fixed sequence, no skipping.
REQ-013 SHALL accept start at edge E0 only when busy=0: capture input_a and round_mode, set busy=1, clear output_done, go to UNPACK.
REQ-014 SHALL ignore start while busy=1; captured operand and mode are not changed.
REQ-015 SHALL transition UNPACK->SPECIAL_CASES->SHIFT->ROUND->PACK on edges E1-E4.
REQ-016 SHALL, at edge E5 (PACK), update output_z, overflow, and underflow, set busy=0 and output_done=1, and return to IDLE; latency is exactly 5 clocks for every input.
REQ-017 SHALL accept a start sampled at E5 only if busy was already 0 before E5; earliest back-to-back accept is at E6.
REQ-018 SHALL hold output_z, overflow, and underflow stable from E5 until the PACK of the next conversion.
REQ-019 SHALL unpack as: sign=a[31]; unbiased exponent e=a[30:23]-127; mantissa m={1,a[22:0]} (24 bits) for normal numbers.
REQ-020 SHALL produce magnitude = m<<(e-23) for e>=23, and m>>(23-e) for 0<=e<23, with guard/round/sticky bits retained for ROUND.
REQ-021 SHALL treat e<0 (magnitude <1) as integer 0, except under RNE with e=-1 and m>24'h800000, which yields 1.
REQ-022 SHALL resolve exact ties under RNE to the even integer; truncate mode SHALL discard all fraction bits.
REQ-023 SHALL apply the sign last by two's-complement negation; rounding SHALL be performed on the magnitude.
REQ-024 SHALL treat zero (exponent 0, fraction 0, either sign) as output 0 with both flags 0.
REQ-025 SHALL treat denormals as output 0 with underflow=1 in both modes.
REQ-026 SHALL set overflow=1 for NaN, ±Inf, and e>=31, except exactly -2^31 (32'hCF000000), which yields 32'h80000000 with overflow=0.
REQ-027 SHALL, on overflow with SATURATE=1, output 32'h7FFFFFFF for positive inputs and NaN, and 32'h80000000 for negative inputs; with SATURATE=0 the output is always 32'h80000000.
REQ-028 SHALL set underflow=1 only when the input is nonzero and the result is 0; overflow and underflow are never both 1.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, set state=IDLE, output_z=0, overflow=0, underflow=0, busy=0, and output_done=0.
REQ-030 SHALL give rst priority over start in the same cycle; rst mid-conversion aborts it, and no output_done is produced for the aborted operand.

Verification
REQ-031 SHALL cover rounding cases:
- 32'h40200000 (2.5) with RNE -> 2.
- 32'h40600000 (3.5) with RNE -> 4.
- 32'hC0200000 (-2.5) with RNE -> 32'hFFFFFFFE.
- 32'h40600000 (3.5) with truncate -> 3.
- 32'h42F6E666 (123.45) -> 123 in both modes.
REQ-032 SHALL cover range limits:
- 32'h4F000000 (2^31) -> 32'h7FFFFFFF, overflow=1.
- 32'hCF000000 -> 32'h80000000, overflow=0.
- SATURATE=0 with 32'h4F000000 -> 32'h80000000.
REQ-033 SHALL cover small-magnitude cases:
- 32'h3F000000 (0.5) with RNE -> 0, underflow=1.
- 32'h3F000001 with RNE -> 1, underflow=0.
- 32'h00000001 -> 0, underflow=1.
- 32'h80000000 -> 0, both flags 0.
REQ-034 SHALL cover special values:
- 32'h7FC00000 (NaN) -> 32'h7FFFFFFF, overflow=1.
- 32'hFF800000 (-Inf) -> 32'h80000000, overflow=1.
REQ-035 SHALL cover the handshake: start held high with input_a changing every cycle -> first operand's result only, output_done exactly 5 clocks after accept, next accept at E6.
REQ-036 SHALL cover reset: rst pulsed at E3 of a conversion -> busy=0 and output_done=0 at the next edge, output_z=0, and a subsequent start converts normally.
